// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and constants for the grant arbiter.
// Holds the one-hot FSM state encoding, the "no owner" id code and a
// one-hot to owner-id helper used by the arbiter datapath.
package arb_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'b001,
      GRANT   = 3'b010,
      RECOVER = 3'b100
   } states_t;

   localparam logic [3:0] NONE_ID = 4'd0;

   // Owner code is index+1 so that 0 can mean "no owner".
   function automatic logic [3:0] onehot_to_id(input logic [7:0] oh);
      logic [3:0] id;
      id = NONE_ID;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) id = 4'(i + 1);
      end
      return id;
   endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// Ports: req (requesters -> arbiter), grant/grant_id/busy/timeout (arbiter -> requesters).
// master = requester side, slave = arbiter side.
interface rr_grant_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic [3:0]       grant_id;
   logic             busy;
   logic             timeout;

   modport master (output req,   input  grant, grant_id, busy, timeout);
   modport slave  (input  req,   output grant, grant_id, busy, timeout);
endinterface

// File: rtl/arb_priority_pick.sv
// Combinational winner selection: scans req downward from start with wrap.
// Ports: req, start (first index to try) -> winner (one-hot), valid.
// Latency: purely combinational, no state.
module arb_priority_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] req,
   input  logic [2:0]       start,
   output logic [N_REQ-1:0] winner,
   output logic             valid
);

   // Outer loop is the priority rank, inner loop finds the bit holding that
   // rank; keeps every vector index a loop constant.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         for (int j = 0; j < N_REQ; j++) begin
            if (!valid && req[j] && (j == (int'(start) + N_REQ - i) % N_REQ)) begin
               winner[j] = 1'b1;
               valid     = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Grant arbiter: one owner at a time, held up to MAX_HOLD cycles, one RECOVER cycle after each ownership.
// Ports: clock, resetN (async, active-low), arb (slave modport: req in; grant, grant_id, busy, timeout out, all registered).
// Macro ARB_ROUND_ROBIN_EN: rotate priority after the last owner; undefined = fixed, highest index wins.
module rr_grant_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 15
) (
   input  logic               clock,
   input  logic               resetN,
   rr_grant_arbiter_if.slave  arb
);

   localparam int              HW        = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

   states_t          state, state_nxt;
   logic [N_REQ-1:0] grant_q, grant_nxt;
   logic [3:0]       id_q, id_nxt;
   logic             busy_q, busy_nxt;
   logic             tmo_q, tmo_nxt;
   logic [HW-1:0]    hold_cnt, hold_nxt;

   logic [2:0]       start_idx;
   logic [N_REQ-1:0] pick_oh;
   logic             pick_vld;
   logic [3:0]       pick_id;
   logic             owner_req;

   assign owner_req = |(arb.req & grant_q);
   assign pick_id   = onehot_to_id(8'(pick_oh));

`ifdef ARB_ROUND_ROBIN_EN
   logic [2:0] last_owner, last_nxt;

   // Start one below the previous owner; last_owner==0 wraps to the top,
   // which also makes the post-reset order equal to the fixed order.
   assign start_idx = (last_owner == 3'd0) ? 3'(N_REQ - 1) : last_owner - 3'd1;

   always_comb begin
      last_nxt = last_owner;
      if (state == IDLE && pick_vld) last_nxt = 3'(pick_id - 4'd1);
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) last_owner <= 3'd0;
      else         last_owner <= last_nxt;
   end
`else
   assign start_idx = 3'(N_REQ - 1);
`endif

   arb_priority_pick #(.N_REQ(N_REQ)) u_pick (
      .req    (arb.req),
      .start  (start_idx),
      .winner (pick_oh),
      .valid  (pick_vld)
   );

   always_comb begin
      state_nxt = state;
      grant_nxt = grant_q;
      id_nxt    = id_q;
      hold_nxt  = hold_cnt;
      tmo_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nxt = GRANT;
               grant_nxt = pick_oh;
               id_nxt    = pick_id;
               hold_nxt  = '0;
            end
         end
         GRANT: begin
            if (owner_req && hold_cnt < HOLD_LAST) begin
               hold_nxt = hold_cnt + HW'(1);
            end else begin
               // Still requesting here means the hold limit ended it.
               state_nxt = RECOVER;
               grant_nxt = '0;
               id_nxt    = NONE_ID;
               tmo_nxt   = owner_req;
            end
         end
         RECOVER: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
            id_nxt    = NONE_ID;
            hold_nxt  = '0;
         end
      endcase
      busy_nxt = (state_nxt == GRANT) || (state_nxt == RECOVER);
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state    <= IDLE;
         grant_q  <= '0;
         id_q     <= NONE_ID;
         busy_q   <= 1'b0;
         tmo_q    <= 1'b0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         grant_q  <= grant_nxt;
         id_q     <= id_nxt;
         busy_q   <= busy_nxt;
         tmo_q    <= tmo_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   assign arb.grant    = grant_q;
   assign arb.grant_id = id_q;
   assign arb.busy     = busy_q;
   assign arb.timeout  = tmo_q;

endmodule
